// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, register address width, result origin.
// Pure declarations; no logic, no latency.
// No flow control.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Outstanding-load scoreboard: one busy bit per register, set on load issue, cleared on load commit.
// busy updates at the clock edge; rsN_busy and ld_issue_ready are combinational lookups.
// Issue is refused (ld_issue_ready=0) while the destination already has a load in flight.
module wb_scoreboard
    import riscv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ld_issue_valid,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    output logic                  ld_issue_ready,
    input  logic                  clr_vld,
    input  logic [REG_ADDR_W-1:0] clr_rd,
`ifndef WB_FORWARD_EN
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
`endif
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_vld;

    assign ld_issue_ready = !busy_q[ld_issue_rd];
    assign set_vld        = ld_issue_valid && ld_issue_ready && (ld_issue_rd != REG_ZERO);

    // Set is applied after clear so a re-issue on the committing rd stays busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_vld) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef WB_FORWARD_EN
    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
`else
    // Without a bypass, the write sitting on the register-file port is not readable yet.
    assign rs1_busy = busy_q[rs1] || (wb_we && (wb_rd == rs1) && (rs1 != REG_ZERO));
    assign rs2_busy = busy_q[rs2] || (wb_we && (wb_rd == rs2) && (rs2 != REG_ZERO));
`endif

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU and load results onto the single register-file write port (WB_FORWARD_EN adds bypass ports).
// One cycle: handshake in N, rf_we/rf_sel_in/rf_data_in valid in N+1.
// ALU wins unless loads were refused STARVE_MAX cycles in a row; then alu_stall holds the ALU until the load commits.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic                  alu_stall,
    input  logic                  ld_issue_valid,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    output logic                  ld_issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_sel_in,
    output logic [XLEN-1:0]       rf_data_in
`ifdef WB_FORWARD_EN
    ,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [XLEN-1:0]       fwd_a_data,
    output logic [XLEN-1:0]       fwd_b_data
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]            starve_cnt;
    logic                  alu_win;
    logic                  mem_hs;
    logic                  any_win;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;
    wb_src_t               win_src;
    wb_src_t               rf_src;

    always_comb begin
        mem_ready = alu_stall || !alu_valid;
        alu_win   = alu_valid && !alu_stall;
        mem_hs    = mem_valid && mem_ready;
        any_win   = alu_win || mem_hs;
        win_rd    = alu_rd;
        win_data  = alu_data;
        win_src   = WB_SRC_ALU;
        if (mem_hs) begin
            win_rd   = mem_rd;
            win_data = mem_data;
            win_src  = WB_SRC_MEM;
        end
    end

    // A refused load is always one with mem_valid high and no handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else if (mem_hs) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else if (mem_valid) begin
            starve_cnt <= starve_cnt + 4'd1;
            if (starve_cnt == STARVE_LIM - 4'd1) begin
                alu_stall <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_sel_in  <= '0;
            rf_data_in <= '0;
            rf_src     <= WB_SRC_ALU;
        end else begin
            rf_we <= any_win && (win_rd != REG_ZERO);
            if (any_win) begin
                rf_sel_in  <= win_rd;
                rf_data_in <= win_data;
                rf_src     <= win_src;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .clr_vld        (rf_we && (rf_src == WB_SRC_MEM)),
        .clr_rd         (rf_sel_in),
`ifndef WB_FORWARD_EN
        .wb_we          (rf_we),
        .wb_rd          (rf_sel_in),
`endif
        .rs1            (rs1),
        .rs2            (rs2),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy)
    );

`ifdef WB_FORWARD_EN
    assign fwd_a_hit  = rf_we && (rf_sel_in == rs1) && (rs1 != REG_ZERO);
    assign fwd_b_hit  = rf_we && (rf_sel_in == rs2) && (rs2 != REG_ZERO);
    assign fwd_a_data = rf_data_in;
    assign fwd_b_data = rf_data_in;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: arbitration, x0 writes, scoreboard, starvation, reset mid-load.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_writeback_unit;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_stall;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_sel_in;
    logic [31:0] rf_data_in;
`ifdef WB_FORWARD_EN
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    writeback_unit #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .alu_stall      (alu_stall),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .rs1            (rs1),
        .rs2            (rs2),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .rf_we          (rf_we),
        .rf_sel_in      (rf_sel_in),
        .rf_data_in     (rf_data_in)
`ifdef WB_FORWARD_EN
        ,
        .fwd_a_hit      (fwd_a_hit),
        .fwd_b_hit      (fwd_b_hit),
        .fwd_a_data     (fwd_a_data),
        .fwd_b_data     (fwd_b_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        mem_valid      = 1'b0;
        mem_rd         = '0;
        mem_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
    endtask

    initial begin
        idle();
        rs1   = '0;
        rs2   = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_rf_we",      32'(rf_we),          32'h0);
        check_eq("rst_rf_sel",     32'(rf_sel_in),      32'h0);
        check_eq("rst_rf_data",    rf_data_in,          32'h0);
        check_eq("rst_alu_stall",  32'(alu_stall),      32'h0);
        check_eq("rst_mem_ready",  32'(mem_ready),      32'h1);
        check_eq("rst_issue_rdy",  32'(ld_issue_ready), 32'h1);
        tick();
        tick();
        reset = 1'b0;

        // ALU write to x1
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        #1 check_eq("alu_mem_ready", 32'(mem_ready), 32'h0);
        tick();
        idle();
        rs1 = 5'd1;
        #1;
        check_eq("alu_rf_we",   32'(rf_we),     32'h1);
        check_eq("alu_rf_sel",  32'(rf_sel_in), 32'h1);
        check_eq("alu_rf_data", rf_data_in,     32'h1);
        check_eq("alu_inflight_busy", 32'(rs1_busy), FWD ? 32'h0 : 32'h1);
`ifdef WB_FORWARD_EN
        check_eq("fwd_a_hit",  32'(fwd_a_hit), 32'h1);
        check_eq("fwd_a_data", fwd_a_data,     32'h1);
        check_eq("fwd_b_miss", 32'(fwd_b_hit), 32'h0);
`endif
        tick();
        check_eq("alu_rf_we_drop", 32'(rf_we), 32'h0);

        // ALU write to x0 never enables the port
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        tick();
        idle();
        check_eq("x0_rf_we", 32'(rf_we), 32'h0);

        // Load to x5: busy while outstanding, clears one cycle after the rf write
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd5;
        #1 check_eq("ld5_issue_rdy", 32'(ld_issue_ready), 32'h1);
        tick();
        ld_issue_valid = 1'b0;
        rs1 = 5'd5; rs2 = 5'd4;
        #1;
        check_eq("ld5_rs1_busy",   32'(rs1_busy),       32'h1);
        check_eq("ld5_rs2_free",   32'(rs2_busy),       32'h0);
        check_eq("ld5_waw_block",  32'(ld_issue_ready), 32'h0);
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEAD;
        #1 check_eq("ld5_mem_ready", 32'(mem_ready), 32'h1);
        tick();
        idle();
        ld_issue_rd = 5'd5;
        #1;
        check_eq("ld5_rf_we",     32'(rf_we),     32'h1);
        check_eq("ld5_rf_sel",    32'(rf_sel_in), 32'h5);
        check_eq("ld5_rf_data",   rf_data_in,     32'hDEAD);
        check_eq("ld5_busy_n1",   32'(rs1_busy),  32'h1);
        tick();
        check_eq("ld5_busy_n2",   32'(rs1_busy),       32'h0);
        check_eq("ld5_issue_n2",  32'(ld_issue_ready), 32'h1);

        // Starvation: ALU held high, load to x6 refused four cycles then forced through
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd6;
        tick();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("starve_ready_%0d", i), 32'(mem_ready), 32'h0);
            check_eq($sformatf("starve_stall_%0d", i), 32'(alu_stall), 32'h0);
            tick();
            check_eq($sformatf("starve_alu_sel_%0d", i), 32'(rf_sel_in), 32'h2);
        end
        check_eq("starve_stall_set", 32'(alu_stall), 32'h1);
        check_eq("starve_ready_set", 32'(mem_ready), 32'h1);
        tick();
        idle();
        check_eq("starve_ld_we",    32'(rf_we),     32'h1);
        check_eq("starve_ld_sel",   32'(rf_sel_in), 32'h6);
        check_eq("starve_ld_data",  rf_data_in,     32'h66);
        check_eq("starve_stall_clr", 32'(alu_stall), 32'h0);
        tick();

        // Commit on x7 on the same edge as a fresh issue to x7: busy must survive
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        tick();
        idle();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        #1 check_eq("same7_issue_rdy", 32'(ld_issue_ready), 32'h1);
        tick();
        ld_issue_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        check_eq("same7_busy",      32'(rs1_busy),       32'h1);
        check_eq("same7_waw_block", 32'(ld_issue_ready), 32'h0);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7777;
        tick();
        idle();
        tick();
        check_eq("same7_cleared", 32'(rs1_busy), 32'h0);

        // Reset in the middle of a starved load to x3
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
        tick();
        idle();
        rs1 = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
        repeat (4) tick();
        check_eq("pre_rst_stall", 32'(alu_stall), 32'h1);
        check_eq("pre_rst_busy3", 32'(rs1_busy),  32'h1);
        check_eq("pre_rst_rf_we", 32'(rf_we),     32'h1);
        #2;
        idle();
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy3",   32'(rs1_busy),       32'h0);
        check_eq("mid_rst_rf_we",   32'(rf_we),          32'h0);
        check_eq("mid_rst_stall",   32'(alu_stall),      32'h0);
        check_eq("mid_rst_rf_data", rf_data_in,          32'h0);
        check_eq("mid_rst_issue3",  32'(ld_issue_ready), 32'h1);
        tick();
        reset = 1'b0;

        // Full-width write to x31 after reset
        alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 32'hFFFF_FFFF;
        tick();
        idle();
        check_eq("post_rst_sel",  32'(rf_sel_in), 32'h1F);
        check_eq("post_rst_data", rf_data_in,     32'hFFFF_FFFF);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
